// File: rtl/tlc_pkg.sv
// ----------------------------------------------------------------------------
// tlc_pkg
// Shared types and constants for the traffic light controller slice.
//   TLC_DW      : duration / countdown width, shared with the register file
//   state_e     : controller states (IDLE, LD, RED, GREEN, YELLOW)
//   phase_e     : lamp phase encoding used to pick the next duration
//   phaseSucc   : RED -> GREEN -> YELLOW -> RED successor
//   phaseState  : maps a phase to the state that displays it
//   toBcd       : two-digit BCD of a countdown value (tens, ones)
// ----------------------------------------------------------------------------
package tlc_pkg;

  localparam int TLC_DW = 6;

  typedef enum logic [2:0] {
    IDLE,
    LD,
    RED,
    GREEN,
    YELLOW
  } state_e;

  typedef enum logic [1:0] {
    PH_RED,
    PH_GREEN,
    PH_YELLOW
  } phase_e;

  function automatic phase_e phaseSucc(input phase_e p);
    case (p)
      PH_RED:   return PH_GREEN;
      PH_GREEN: return PH_YELLOW;
      default:  return PH_RED;
    endcase
  endfunction

  function automatic state_e phaseState(input phase_e p);
    case (p)
      PH_GREEN:  return GREEN;
      PH_YELLOW: return YELLOW;
      default:   return RED;
    endcase
  endfunction

  // Countdown values never exceed 99 for the default width, so two digits suffice.
  function automatic logic [7:0] toBcd(input int unsigned v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/tlc_rf_if.sv
// ----------------------------------------------------------------------------
// tlc_rf_if
// Read bus between the traffic light controller and the duration register
// file.
//   rf_rd_req : read request, high for the single cycle a duration is fetched
//   r_r/r_g/r_y : red / green / yellow durations in seconds (DW bits each)
// Modports:
//   master : the controller (drives rf_rd_req, reads durations)
//   slave  : the register file side (reads rf_rd_req, drives durations)
// ----------------------------------------------------------------------------
interface tlc_rf_if
  import tlc_pkg::*;
#(
  parameter int DW = TLC_DW
) ();

  logic          rf_rd_req;
  logic [DW-1:0] r_r;
  logic [DW-1:0] r_g;
  logic [DW-1:0] r_y;

  modport master (output rf_rd_req, input r_r, input r_g, input r_y);
  modport slave  (input rf_rd_req, output r_r, output r_g, output r_y);

endinterface

// File: rtl/tlc_prescaler.sv
// ----------------------------------------------------------------------------
// tlc_prescaler
// Divides the system clock down to a one-second tick.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   clr_i   : synchronous clear, restarts the second from zero
//   tick_o  : high during the last clock of each second (count == CLK_DIV-1)
// Parameter CLK_DIV (>= 2) is the number of clocks per second.
// ----------------------------------------------------------------------------
module tlc_prescaler #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] presc_q;

  assign tick_o = (presc_q == LAST);

  // Free-running 0..CLK_DIV-1 counter; a clear wins so a new phase always
  // gets a full first second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (clr_i || tick_o) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + CW'(1);
    end
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// ----------------------------------------------------------------------------
// traffic_light_fsm
// Sequences RED -> GREEN -> YELLOW -> RED. Each phase's duration is fetched
// from the register file in a one-cycle LD state at phase entry, then counted
// down one second per prescaler tick.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   run        : 1 runs the sequence, 0 forces IDLE (red lamp)
//   rf         : tlc_rf_if.master read bus (rf_rd_req out, r_r/r_g/r_y in)
//   lamp_r/g/y : lamp drives, exactly one high at any time
//   remain     : seconds left in the current phase, 0 in IDLE
// Optional macro TLC_BCD_DISP_EN adds remain_tens / remain_ones, the BCD
// digits of remain, registered alongside it.
// ----------------------------------------------------------------------------
module traffic_light_fsm
  import tlc_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000,
  parameter int DW      = TLC_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  tlc_rf_if.master      rf,
  output logic          lamp_r,
  output logic          lamp_g,
  output logic          lamp_y,
  output logic [DW-1:0] remain
`ifdef TLC_BCD_DISP_EN
  ,
  output logic [3:0]    remain_tens,
  output logic [3:0]    remain_ones
`endif
);

  state_e        state_q, state_d;
  phase_e        next_ph_q, next_ph_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] sel_dur;
  logic [DW-1:0] remain_d;
  logic [2:0]    lamps_d;
  logic          tick;
  logic          presc_clr;

  // The second restarts whenever we are not counting a phase, so each phase
  // is exactly duration*CLK_DIV clocks long.
  assign presc_clr = (state_q == IDLE) || (state_q == LD) || !run;

  tlc_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (presc_clr),
    .tick_o (tick)
  );

  // Next-state, countdown and lamp decode. In phase states next_ph_q holds
  // the phase being shown, so its successor is the phase to load next.
  always_comb begin
    state_d   = state_q;
    next_ph_d = next_ph_q;
    cnt_d     = cnt_q;
    lamps_d   = {lamp_r, lamp_g, lamp_y};

    case (next_ph_q)
      PH_GREEN:  sel_dur = rf.r_g;
      PH_YELLOW: sel_dur = rf.r_y;
      default:   sel_dur = rf.r_r;
    endcase

    if (!run) begin
      state_d   = IDLE;
      next_ph_d = PH_RED;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = LD;
          next_ph_d = PH_RED;
        end
        LD: begin
          cnt_d   = (sel_dur == '0) ? DW'(1) : sel_dur;
          state_d = phaseState(next_ph_q);
        end
        RED, GREEN, YELLOW: begin
          if (tick) begin
            if (cnt_q > DW'(1)) begin
              cnt_d = cnt_q - DW'(1);
            end else begin
              next_ph_d = phaseSucc(next_ph_q);
              state_d   = LD;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          next_ph_d = PH_RED;
          cnt_d     = '0;
        end
      endcase
    end

    // LD keeps whatever lamp was already on, which is red when leaving IDLE.
    case (state_d)
      IDLE, RED: lamps_d = 3'b100;
      GREEN:     lamps_d = 3'b010;
      YELLOW:    lamps_d = 3'b001;
      default:   lamps_d = {lamp_r, lamp_g, lamp_y};
    endcase

    remain_d = (state_d == IDLE) ? '0 : cnt_d;
  end

  // State plus registered outputs; outputs are decoded from the next state
  // so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      next_ph_q    <= PH_RED;
      cnt_q        <= '0;
      lamp_r       <= 1'b1;
      lamp_g       <= 1'b0;
      lamp_y       <= 1'b0;
      remain       <= '0;
      rf.rf_rd_req <= 1'b0;
`ifdef TLC_BCD_DISP_EN
      remain_tens  <= '0;
      remain_ones  <= '0;
`endif
    end else begin
      state_q                  <= state_d;
      next_ph_q                <= next_ph_d;
      cnt_q                    <= cnt_d;
      {lamp_r, lamp_g, lamp_y} <= lamps_d;
      remain                   <= remain_d;
      rf.rf_rd_req             <= (state_d == LD);
`ifdef TLC_BCD_DISP_EN
      {remain_tens, remain_ones} <= toBcd(int'(remain_d));
`endif
    end
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// ----------------------------------------------------------------------------
// tb_traffic_light_fsm
// Scoreboard bench for traffic_light_fsm with CLK_DIV=4. A reference model
// tracks phase, duration and clocks elapsed in the phase, and pushes the
// expected outputs for each clock edge into a queue; a monitor pops and
// compares on every falling edge.
// ----------------------------------------------------------------------------
module tb_traffic_light_fsm;
  import tlc_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int DW      = TLC_DW;

  typedef struct packed {
    logic [2:0]    lamps;
    logic [DW-1:0] remain;
    logic          rdReq;
  } expect_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic          lamp_r, lamp_g, lamp_y;
  logic [DW-1:0] remain;
`ifdef TLC_BCD_DISP_EN
  logic [3:0]    remain_tens, remain_ones;
`endif

  tlc_rf_if #(.DW(DW)) rfBus ();

  traffic_light_fsm #(.CLK_DIV(CLK_DIV), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .rf          (rfBus),
    .lamp_r      (lamp_r),
    .lamp_g      (lamp_g),
    .lamp_y      (lamp_y),
    .remain      (remain)
`ifdef TLC_BCD_DISP_EN
    ,
    .remain_tens (remain_tens),
    .remain_ones (remain_ones)
`endif
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  expect_t expQ[$];

  // Reference model: mode 0 = idle, 1 = loading, 2 = showing a phase.
  int         mMode, mPhase, mNextPh, mDur, mElapsed, mRemain;
  logic [2:0] mLamps;
  bit         mRd;
  int         curR, curG, curY;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task modelReset();
    mMode = 0; mPhase = 0; mNextPh = 0; mDur = 0; mElapsed = 0;
    mRemain = 0; mLamps = 3'b100; mRd = 1'b0;
  endtask

  function automatic int durFor(input int ph);
    int d;
    d = (ph == 0) ? int'(rfBus.r_r) : (ph == 1) ? int'(rfBus.r_g) : int'(rfBus.r_y);
    return (d == 0) ? 1 : d;
  endfunction

  // One clock edge of the model, using the inputs the DUT just sampled.
  task modelStep();
    logic [2:0] redLamp;
    expect_t    e;
    redLamp = 3'b100;
    if (!rst_n) begin
      modelReset();
    end else if (!run) begin
      mMode = 0; mNextPh = 0; mLamps = 3'b100; mRemain = 0; mRd = 1'b0;
    end else begin
      case (mMode)
        0: begin
          mMode = 1; mNextPh = 0; mRd = 1'b1; mRemain = 0;
        end
        1: begin
          mDur = durFor(mNextPh); mPhase = mNextPh; mElapsed = 0;
          mMode = 2; mLamps = redLamp >> mPhase; mRemain = mDur; mRd = 1'b0;
        end
        default: begin
          mElapsed++;
          if (mElapsed == mDur * CLK_DIV) begin
            mMode = 1; mNextPh = (mPhase + 1) % 3; mRd = 1'b1; mRemain = 1;
          end else begin
            mRemain = mDur - mElapsed / CLK_DIV;
          end
        end
      endcase
    end
    e.lamps  = mLamps;
    e.remain = DW'(mRemain);
    e.rdReq  = mRd;
    expQ.push_back(e);
  endtask

  // Drive inputs for one cycle on the falling edge, then advance the model.
  task applyStimulus(input bit newRstn, input bit newRun);
    @(negedge clk);
    rst_n = newRstn;
    run   = newRun;
    rfBus.r_r = DW'(curR);
    rfBus.r_g = DW'(curG);
    rfBus.r_y = DW'(curY);
    @(posedge clk);
    modelStep();
  endtask

  task runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1);
  endtask

  // Monitor: every falling edge compares the outputs produced by the last edge.
  always @(negedge clk) begin
    expect_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("lamps", int'({lamp_r, lamp_g, lamp_y}), int'(e.lamps));
      checkOutput("remain", int'(remain), int'(e.remain));
      checkOutput("rf_rd_req", int'(rfBus.rf_rd_req), int'(e.rdReq));
      checkOutput("one lamp", $countones({lamp_r, lamp_g, lamp_y}), 1);
`ifdef TLC_BCD_DISP_EN
      checkOutput("remain_tens", int'(remain_tens), int'(e.remain) / 10);
      checkOutput("remain_ones", int'(remain_ones), int'(e.remain) % 10);
`endif
    end
  end

  initial begin
    rst_n = 1'b0; run = 1'b0;
    curR = 3; curG = 2; curY = 1;
    rfBus.r_r = DW'(curR); rfBus.r_g = DW'(curG); rfBus.r_y = DW'(curY);
    modelReset();

    // Power-on reset, then release with run low, then start.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    runCycles(2 * 27 + 3);

    // Asynchronous reset in the middle of GREEN.
    for (int i = 0; i < 100 && !(mMode == 2 && mPhase == 1 && mElapsed == 3); i++)
      applyStimulus(1'b1, 1'b1);
    checkOutput("reach GREEN", int'(mMode == 2 && mPhase == 1), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async lamp_r", int'(lamp_r), 1);
    checkOutput("async lamp_g", int'(lamp_g), 0);
    checkOutput("async lamp_y", int'(lamp_y), 0);
    checkOutput("async remain", int'(remain), 0);
    checkOutput("async rf_rd_req", int'(rfBus.rf_rd_req), 0);
    expQ.delete();
    modelReset();
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);

    // Zero yellow duration is stretched to one second.
    curY = 0;
    runCycles(2 * 27 + 2);

    // Change green while it is being shown; only the next green uses it.
    curY = 1;
    for (int i = 0; i < 100 && !(mMode == 2 && mPhase == 1); i++) applyStimulus(1'b1, 1'b1);
    checkOutput("reach GREEN 2", int'(mMode == 2 && mPhase == 1), 1);
    curG = 5;
    runCycles(60);

    // Drop run on the tick cycle of RED, idle a while, restart.
    for (int i = 0; i < 200 && !(mMode == 2 && mPhase == 0 && mElapsed % CLK_DIV == CLK_DIV - 1); i++)
      applyStimulus(1'b1, 1'b1);
    checkOutput("reach RED tick", int'(mMode == 2 && mPhase == 0), 1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    curR = 47;
    runCycles(8);
    curR = 63;
    applyStimulus(1'b1, 1'b0);
    runCycles(12);

    // Randomized run drops and register-file updates.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        curR = ($urandom_range(0, 19) == 0) ? 63 : int'($urandom_range(0, 6));
        curG = int'($urandom_range(0, 6));
        curY = int'($urandom_range(0, 6));
      end
      applyStimulus(1'b1, $urandom_range(0, 59) != 0);
    end

    @(negedge clk);
    #1;
    checkOutput("queue drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
